// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for the SoC reset tree.
// Asserts the targeted domains, holds them for HOLD_CYC cycles, then
// releases them in ascending index with GAP_CYC cycles between releases.
// Handles watchdog resets (highest priority) and masked software resets
// with a req/ack handshake. All outputs are registered.
module rst_seq_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wdt_rst_i,
  input  logic               sw_rst_req_i,
  input  logic [NUM_DOM-1:0] sw_rst_mask_i,
  output logic [NUM_DOM-1:0] dom_rstn_o,
  output logic               rst_busy_o,
  output logic               sw_rst_ack_o,
  output logic [1:0]         rst_cause_o
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_WDT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_DOM-1:0] r_pending;
  logic [NUM_DOM-1:0] r_dom;
  logic               r_busy;
  logic               r_ack;
  logic [1:0]         r_cause;
  logic               r_sw_seq;

  logic [NUM_DOM-1:0] w_low;
  logic [NUM_DOM-1:0] w_pend_nxt;
  logic               w_release;

  // Pick the lowest still-pending domain and decide whether this edge releases it.
  // The pending set replaces an explicit index: untargeted bits are never in it,
  // so skipping them costs no cycles.
  always_comb begin
    w_low      = r_pending & (~r_pending + NUM_DOM'(1));
    w_pend_nxt = r_pending & ~w_low;
    w_release  = 1'b0;
    case (r_state)
      S_HOLD:    w_release = (r_cnt == CNT_W'(HOLD_CYC - 1));
      S_RELEASE: w_release = (r_cnt == '0);
      default:   w_release = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs; reset and watchdog override everything.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_pending <= '1;
      r_dom     <= '0;
      r_busy    <= 1'b1;
      r_ack     <= 1'b0;
      r_cause   <= CAUSE_POR;
      r_sw_seq  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (wdt_rst_i) begin
        r_state   <= S_HOLD;
        r_cnt     <= '0;
        r_pending <= '1;
        r_dom     <= '0;
        r_busy    <= 1'b1;
        r_cause   <= CAUSE_WDT;
        r_sw_seq  <= 1'b0;
      end else begin
        case (r_state)
          S_HOLD, S_RELEASE: begin
            if (w_release) begin
              // The first release happens on the last HOLD edge itself, so
              // the first domain rises exactly HOLD_CYC edges after the start.
              r_dom     <= r_dom | w_low;
              r_pending <= w_pend_nxt;
              r_cnt     <= CNT_W'(GAP_CYC - 1);
              if (w_pend_nxt == '0) begin
                r_state  <= S_RUN;
                r_busy   <= 1'b0;
                r_ack    <= r_sw_seq;
                r_sw_seq <= 1'b0;
              end else begin
                r_state <= S_RELEASE;
              end
            end else if (r_state == S_HOLD) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_RUN: begin
            if (sw_rst_req_i && !r_ack) begin
              if (sw_rst_mask_i != '0) begin
                r_state   <= S_HOLD;
                r_cnt     <= '0;
                r_pending <= sw_rst_mask_i;
                r_dom     <= r_dom & ~sw_rst_mask_i;
                r_busy    <= 1'b1;
                r_cause   <= CAUSE_SW;
                r_sw_seq  <= 1'b1;
              end else begin
                r_ack <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign dom_rstn_o   = r_dom;
  assign rst_busy_o   = r_busy;
  assign sw_rst_ack_o = r_ack;
  assign rst_cause_o  = r_cause;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench for rst_seq_ctrl. A timestamp-based
// reference model predicts the outputs after every clock edge and queues them;
// a monitor pops and compares on the falling edge.
module tb_rst_seq_ctrl;

  localparam int NUM_DOM  = 4;
  localparam int HOLD_CYC = 16;
  localparam int GAP_CYC  = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               wdt_rst_i;
  logic               sw_rst_req_i;
  logic [NUM_DOM-1:0] sw_rst_mask_i;
  logic [NUM_DOM-1:0] dom_rstn_o;
  logic               rst_busy_o;
  logic               sw_rst_ack_o;
  logic [1:0]         rst_cause_o;

  rst_seq_ctrl #(
    .NUM_DOM (NUM_DOM),
    .HOLD_CYC(HOLD_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wdt_rst_i    (wdt_rst_i),
    .sw_rst_req_i (sw_rst_req_i),
    .sw_rst_mask_i(sw_rst_mask_i),
    .dom_rstn_o   (dom_rstn_o),
    .rst_busy_o   (rst_busy_o),
    .sw_rst_ack_o (sw_rst_ack_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NUM_DOM-1:0] dom;
    logic               busy;
    logic               ack;
    logic [1:0]         cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: a sequence is described by its start edge and target set.
  int                 m_edge   = 0;
  int                 m_start  = 0;
  bit                 m_active = 1'b1;
  bit                 m_sw     = 1'b0;
  bit                 m_ack    = 1'b0;
  logic [NUM_DOM-1:0] m_tgt    = '1;
  logic [NUM_DOM-1:0] m_dom    = '0;
  logic [1:0]         m_cause  = 2'b00;

  // Model: k-th targeted domain rises at start + HOLD + k*GAP; the last rise ends the sequence.
  always @(posedge clk_i) begin : model
    int   k;
    bit   nack;
    exp_t e;
    m_edge = m_edge + 1;
    nack   = 1'b0;
    if (!rst_ni) begin
      m_dom = '0; m_tgt = '1; m_start = m_edge; m_active = 1'b1; m_sw = 1'b0; m_cause = 2'b00;
    end else if (wdt_rst_i) begin
      m_dom = '0; m_tgt = '1; m_start = m_edge; m_active = 1'b1; m_sw = 1'b0; m_cause = 2'b01;
    end else if (m_active) begin
      k = 0;
      for (int j = 0; j < NUM_DOM; j++) begin
        if (m_tgt[j]) begin
          if (m_edge == m_start + HOLD_CYC + k * GAP_CYC) m_dom[j] = 1'b1;
          k = k + 1;
        end
      end
      if (m_edge == m_start + HOLD_CYC + (k - 1) * GAP_CYC) begin
        m_active = 1'b0;
        nack     = m_sw;
        m_sw     = 1'b0;
      end
    end else if (sw_rst_req_i && !m_ack) begin
      if (sw_rst_mask_i != '0) begin
        m_tgt    = sw_rst_mask_i;
        m_dom    = m_dom & ~sw_rst_mask_i;
        m_start  = m_edge;
        m_active = 1'b1;
        m_sw     = 1'b1;
        m_cause  = 2'b10;
      end else begin
        nack = 1'b1;
      end
    end
    m_ack   = nack;
    e.dom   = m_dom;
    e.busy  = m_active;
    e.ack   = m_ack;
    e.cause = m_cause;
    exp_q.push_back(e);
  end

  // Monitor: compare every DUT output against the queued prediction.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests = n_tests + 1;
      if (dom_rstn_o !== e.dom) begin
        n_fail = n_fail + 1;
        $display("FAIL dom t=%0t got=%b exp=%b", $time, dom_rstn_o, e.dom);
      end
      n_tests = n_tests + 1;
      if (rst_busy_o !== e.busy) begin
        n_fail = n_fail + 1;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, rst_busy_o, e.busy);
      end
      n_tests = n_tests + 1;
      if (sw_rst_ack_o !== e.ack) begin
        n_fail = n_fail + 1;
        $display("FAIL ack t=%0t got=%b exp=%b", $time, sw_rst_ack_o, e.ack);
      end
      n_tests = n_tests + 1;
      if (rst_cause_o !== e.cause) begin
        n_fail = n_fail + 1;
        $display("FAIL cause t=%0t got=%b exp=%b", $time, rst_cause_o, e.cause);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_ack(input int bound, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (sw_rst_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_tests = n_tests + 1;
    if (!got) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=no_ack exp=ack_within_%0d", nm, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (rst_busy_o === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    n_tests = n_tests + 1;
    if (!got) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=busy exp=idle_within_%0d", nm, bound);
    end
  endtask

  function automatic logic [NUM_DOM-1:0] rand_nz_mask();
    logic [NUM_DOM-1:0] m;
    m = NUM_DOM'($urandom_range(1, (1 << NUM_DOM) - 1));
    return m;
  endfunction

  // Stimulus: directed scenarios followed by a randomized mix.
  initial begin
    rst_ni = 1'b0; wdt_rst_i = 1'b0; sw_rst_req_i = 1'b0; sw_rst_mask_i = '0;
    // POR
    cyc(5);
    rst_ni = 1'b1;
    wait_idle(100, "por_idle");
    cyc(3);
    // SW reset of domains 1 and 3; mask changes after acceptance must not matter
    sw_rst_req_i = 1'b1; sw_rst_mask_i = 4'b1010;
    cyc(1);
    sw_rst_mask_i = NUM_DOM'($urandom);
    wait_ack(100, "sw_ack");
    sw_rst_req_i = 1'b0;
    cyc(3);
    // SW zero mask
    sw_rst_req_i = 1'b1; sw_rst_mask_i = '0;
    wait_ack(5, "zero_ack");
    sw_rst_req_i = 1'b0;
    cyc(3);
    // WDT abort during RELEASE of a SW sequence
    sw_rst_req_i = 1'b1; sw_rst_mask_i = 4'b1010;
    cyc(20);
    wdt_rst_i = 1'b1; sw_rst_req_i = 1'b0;
    cyc(1);
    wdt_rst_i = 1'b0;
    wait_idle(100, "wdt_idle");
    cyc(3);
    // WDT and SW on the same RUN cycle; held request served afterwards
    wdt_rst_i = 1'b1; sw_rst_req_i = 1'b1; sw_rst_mask_i = rand_nz_mask();
    cyc(1);
    wdt_rst_i = 1'b0;
    wait_ack(200, "prio_ack");
    sw_rst_req_i = 1'b0;
    cyc(3);
    // rst_ni during HOLD of a SW sequence
    sw_rst_req_i = 1'b1; sw_rst_mask_i = rand_nz_mask();
    cyc(5);
    rst_ni = 1'b0; sw_rst_req_i = 1'b0;
    cyc(2);
    rst_ni = 1'b1;
    wait_idle(100, "rst_idle");
    cyc(3);
    // Randomized mix
    repeat (40) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          sw_rst_req_i = 1'b1; sw_rst_mask_i = NUM_DOM'($urandom);
          cyc($urandom_range(1, 60));
          sw_rst_req_i = 1'b0;
        end
        5, 6: begin
          wdt_rst_i = 1'b1;
          cyc($urandom_range(1, 4));
          wdt_rst_i = 1'b0;
        end
        7: begin
          sw_rst_req_i = 1'b1; sw_rst_mask_i = rand_nz_mask();
          cyc($urandom_range(10, 40));
          wdt_rst_i = 1'b1;
          cyc(1);
          wdt_rst_i = 1'b0;
          cyc($urandom_range(1, 30));
          sw_rst_req_i = 1'b0;
        end
        8: begin
          rst_ni = 1'b0;
          cyc($urandom_range(1, 3));
          rst_ni = 1'b1;
        end
        default: cyc($urandom_range(1, 50));
      endcase
      cyc($urandom_range(0, 10));
    end
    wait_idle(200, "final_idle");
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
